bcd_to_bin: RTL and testbench



---
 rtl/bcd_to_bin.sv | 118 +++++++++++
 tb/tb_bcd_to_bin.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: four-digit BCD to 14-bit binary converter.
// A digit set is captured in IDLE, folded into the accumulator one digit per
// clock (most-significant first, acc = acc*10 + digit), then held in DONE
// until the consumer takes it. Any digit above 9 forces number = 0, error = 1.
module bcd_to_bin (
  input  logic        clk,
  input  logic        srst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] number,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] digits_reg;
  logic [13:0] acc_reg;
  logic [1:0]  idx_reg;
  logic        err_reg;
  logic        out_valid_reg;
  logic [13:0] number_reg;
  logic        error_reg;

  logic [15:0] in_digits;
  logic [3:0]  digit_bad;
  logic [3:0]  digit_sel;
  logic [13:0] acc_next;

  assign in_digits = {thousands, hundreds, tens, ones};

  // One range flag per incoming digit; any flag marks the whole set invalid.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_check
      assign digit_bad[gi] = (in_digits[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  // Pick the captured digit for the current step, thousands first.
  always_comb begin
    digit_sel = 4'd0;
    case (idx_reg)
      2'd0:    digit_sel = digits_reg[15:12];
      2'd1:    digit_sel = digits_reg[11:8];
      2'd2:    digit_sel = digits_reg[7:4];
      default: digit_sel = digits_reg[3:0];
    endcase
  end

  // acc*10 as shift-and-add; acc <= 999 here so the result fits in 14 bits.
  assign acc_next = (acc_reg << 3) + (acc_reg << 1) + {10'd0, digit_sel};

  // Handshake FSM with registered outputs; reset aborts any in-flight result.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= IDLE;
      digits_reg    <= 16'd0;
      acc_reg       <= 14'd0;
      idx_reg       <= 2'd0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      number_reg    <= 14'd0;
      error_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            digits_reg <= in_digits;
            acc_reg    <= 14'd0;
            idx_reg    <= 2'd0;
            err_reg    <= |digit_bad;
            state_reg  <= CONV;
          end
        end
        CONV: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            number_reg    <= err_reg ? 14'd0 : acc_next;
            error_reg     <= err_reg;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            number_reg    <= 14'd0;
            error_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          number_reg    <= 14'd0;
          error_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) & ~srst;
  assign out_valid = out_valid_reg;
  assign number    = number_reg;
  assign error     = error_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed checks of latency, boundaries, invalid digits,
// backpressure, mid-conversion reset and streamed conversions.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        srst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] number;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bcd_to_bin dut (
    .clk       (clk),
    .srst      (srst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .number    (number),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Accept one digit set, measure latency, check the result, then drain it.
  task automatic convert(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input int exp_num, input logic exp_err);
    int cnt;
    @(negedge clk);
    thousands = d3; hundreds = d2; tens = d1; ones = d0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("conv_no_valid", out_valid, 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 4);
    check("number", number, exp_num);
    check("error", error, exp_err);
    check("done_not_ready", in_ready, 0);
    $display("convert %0h%0h%0h%0h -> number %0d error %0b latency %0d", d3, d2, d1, d0, number, error, cnt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drained_valid", out_valid, 0);
    check("drained_number", number, 0);
    check("idle_ready", in_ready, 1);
  endtask

  function automatic int model(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return 0;
    return d3 * 1000 + d2 * 100 + d1 * 10 + d0;
  endfunction

  // Stream n random sets; with stall set, out_ready is randomized each cycle.
  task automatic stream(input int n, input bit stall);
    int prev_acc;
    int acc_cyc;
    int got;
    int w;
    logic [3:0] d3, d2, d1, d0;
    int exp_num;
    bit taken;
    got = 0;
    prev_acc = 0;
    for (int k = 0; k < n; k++) begin
      d3 = 4'($urandom_range(0, 9)); d2 = 4'($urandom_range(0, 9));
      d1 = 4'($urandom_range(0, 9)); d0 = 4'($urandom_range(0, 9));
      exp_num = model(d3, d2, d1, d0);
      @(negedge clk);
      thousands = d3; hundreds = d2; tens = d1; ones = d0;
      in_valid = 1'b1;
      if (!stall) out_ready = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("stream_accept", in_ready, 1);
      acc_cyc = cyc;
      if (!stall && k > 0) check("stream_period", acc_cyc - prev_acc, 6);
      prev_acc = acc_cyc;
      taken = 1'b0;
      w = 0;
      while (!taken && w < 100) begin
        @(negedge clk);
        w++;
        if (stall) out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          taken = 1'b1;
          got++;
          check("stream_number", number, exp_num);
          check("stream_error", error, 0);
          $display("stream k=%0d stall=%0b digits %0d%0d%0d%0d -> number %0d", k, stall, d3, d2, d1, d0, number);
        end
      end
      check("stream_taken", taken, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", got, n);
    // The last transfer retires the result; a duplicate would show here.
    check("stream_no_dup", out_valid, 0);
  endtask

  initial begin
    srst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_number", number, 0);
    check("rst_error", error, 0);
    srst = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);
    $display("reset released in_ready %0b", in_ready);

    convert(4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0);
    convert(4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0);
    convert(4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    convert(4'd0, 4'd0, 4'd0, 4'd7, 7, 1'b0);
    convert(4'd3, 4'd5, 4'hA, 4'd1, 0, 1'b1);
    convert(4'hF, 4'd2, 4'd3, 4'd4, 0, 1'b1);

    // Backpressure: 5001 held while out_ready is low, new requests ignored.
    @(negedge clk);
    thousands = 4'd5; hundreds = 4'd0; tens = 4'd0; ones = 4'd1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    thousands = 4'd9; hundreds = 4'd8; tens = 4'd7; ones = 4'd6;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_number", number, 5001);
      check("bp_error", error, 0);
      check("bp_in_ready", in_ready, 0);
      $display("backpressure cycle %0d number %0d", i, number);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Reset two cycles into a conversion; the aborted result must never appear.
    @(negedge clk);
    thousands = 4'd8; hundreds = 4'd8; tens = 4'd8; ones = 4'd8;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_number", number, 0);
    check("abort_in_ready", in_ready, 0);
    srst = 1'b0;
    #1;
    check("abort_release_ready", in_ready, 1);
    $display("mid-conversion reset released in_ready %0b", in_ready);
    convert(4'd0, 4'd0, 4'd4, 4'd2, 42, 1'b0);

    stream(10, 1'b0);
    stream(10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
